// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit serializer.
// Optional parity is controlled by the macro UART_TX_PARIDAD_EN (see uart_tx_serie).
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    START,
    DATA,
    PAR,
    STOP
  } state_t;

  localparam logic TX_IDLE = 1'b1;

  // Bit counter width able to hold 0..n.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  localparam int unsigned CNT_W = cnt_width(8);

endpackage

// File: rtl/uart_tx_serie_if.sv
// Request/status bundle between a frame producer and uart_tx_serie.
interface uart_tx_serie_if #(
  parameter int unsigned DATA_W = 8
) ();

  logic              go;
  logic [DATA_W-1:0] dato;
  logic              busy;
  logic              done;

  modport master (output go, output dato, input busy, input done);
  modport slave  (input go, input dato, output busy, output done);

endinterface

// File: rtl/det_flanco_baud.sv
// Falling-edge detector on the divided baud wave; ckd is treated as data.
module det_flanco_baud (
  input  logic ck,
  input  logic rst,
  input  logic ckd,
  output logic tick
);

  logic ckd_q;

  // Delay ckd by one ck; reset high so an idle (high) ckd never yields a tick.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) ckd_q <= 1'b1;
    else     ckd_q <= ckd;
  end

  assign tick = ckd_q & ~ckd;

endmodule

// File: rtl/uart_tx_serie.sv
// UART transmit serializer: start bit, DATA_W bits LSB first, optional even
// parity, STOP_BITS stop bits. Bit timing comes from the falling edge of ckd.
// Macro UART_TX_PARIDAD_EN: when defined, inserts one even-parity bit before STOP.
module uart_tx_serie
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic            ck,
  input  logic            rst,
  uart_tx_serie_if.slave  bus,
  input  logic            ckd,
  output logic            f,
  output logic            tx
);

  localparam int unsigned CW = cnt_width(DATA_W);

  state_t            state;
  logic [DATA_W-1:0] shift;
  logic [CW-1:0]     cnt;
  logic              tick;
  logic              busy_r;
  logic              done_r;
`ifdef UART_TX_PARIDAD_EN
  logic              par;
`endif

  det_flanco_baud u_det (
    .ck   (ck),
    .rst  (rst),
    .ckd  (ckd),
    .tick (tick)
  );

  assign bus.busy = busy_r;
  assign bus.done = done_r;

  // Frame sequencer; tx is registered, so a level follows the tick that selects it.
  // In DATA the next bit is read as shift[1] since the shift lands on the same edge.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      tx     <= TX_IDLE;
      f      <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      shift  <= '0;
      cnt    <= '0;
`ifdef UART_TX_PARIDAD_EN
      par    <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          tx <= TX_IDLE;
          f  <= 1'b0;
          if (bus.go) begin
            shift  <= bus.dato;
            cnt    <= '0;
            busy_r <= 1'b1;
            f      <= 1'b1;
            state  <= ARM;
`ifdef UART_TX_PARIDAD_EN
            par    <= ^bus.dato;
`endif
          end
        end
        ARM: begin
          if (tick) begin
            state <= START;
            tx    <= 1'b0;
          end
        end
        START: begin
          if (tick) begin
            state <= DATA;
            tx    <= shift[0];
            cnt   <= '0;
          end
        end
        DATA: begin
          if (tick) begin
            shift <= shift >> 1;
            if (cnt == CW'(DATA_W - 1)) begin
              cnt <= '0;
`ifdef UART_TX_PARIDAD_EN
              state <= PAR;
              tx    <= par;
`else
              state <= STOP;
              tx    <= TX_IDLE;
`endif
            end else begin
              cnt <= cnt + 1'b1;
              tx  <= shift[1];
            end
          end
        end
        PAR: begin
`ifdef UART_TX_PARIDAD_EN
          if (tick) begin
            state <= STOP;
            tx    <= TX_IDLE;
            cnt   <= '0;
          end
`else
          state <= IDLE;
          tx    <= TX_IDLE;
`endif
        end
        STOP: begin
          if (tick) begin
            if (cnt == CW'(STOP_BITS - 1)) begin
              state  <= IDLE;
              done_r <= 1'b1;
              f      <= 1'b0;
              busy_r <= 1'b0;
              cnt    <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          tx    <= TX_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serie.sv
// Bench for uart_tx_serie with a divide-by-5 baud divider model (bit = 10 ck).
// Follows UART_TX_PARIDAD_EN the same way as the RTL.
module tb_uart_tx_serie;

`ifdef UART_TX_PARIDAD_EN
  localparam int NPAR = 1;
`else
  localparam int NPAR = 0;
`endif

  logic ck = 1'b0;
  logic rst;
  logic ckd1, ckd2, f1, f2, tx1, tx2;
  int   c1, c2;

  int n_checks = 0;
  int n_fail   = 0;

  logic txq[$];
  logic busyq[$];
  logic fq[$];
  int   done_idx;
  int   done_cnt;

  always #5 ck = ~ck;

  uart_tx_serie_if #(.DATA_W(8)) b1 ();
  uart_tx_serie_if #(.DATA_W(8)) b2 ();

  uart_tx_serie #(.DATA_W(8), .STOP_BITS(1)) dut1 (
    .ck(ck), .rst(rst), .bus(b1), .ckd(ckd1), .f(f1), .tx(tx1)
  );

  uart_tx_serie #(.DATA_W(8), .STOP_BITS(2)) dut2 (
    .ck(ck), .rst(rst), .bus(b2), .ckd(ckd2), .f(f2), .tx(tx2)
  );

  // Baud divider model: holds ckd high while f=0, toggles every 5 ck otherwise.
  always @(posedge ck or posedge rst) begin
    if (rst || !f1) begin c1 <= 0; ckd1 <= 1'b1; end
    else if (c1 == 4) begin c1 <= 0; ckd1 <= ~ckd1; end
    else c1 <= c1 + 1;
  end

  always @(posedge ck or posedge rst) begin
    if (rst || !f2) begin c2 <= 0; ckd2 <= 1'b1; end
    else if (c2 == 4) begin c2 <= 0; ckd2 <= ~ckd2; end
    else c2 <= c2 + 1;
  end

  function automatic logic exp_level(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
`ifdef UART_TX_PARIDAD_EN
    if (k == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  function automatic int nlev(input int stops);
    return 1 + 8 + NPAR + stops;
  endfunction

  function automatic int first_zero(input int from);
    for (int i = from; i < txq.size(); i++) if (txq[i] === 1'b0) return i;
    return -1;
  endfunction

  // Number of samples in bit slot k (10 samples from s) that differ from e.
  function automatic int level_err(input int s, input int k, input logic e);
    int n = 0;
    for (int j = 0; j < 10; j++) begin
      int idx = s + 10 * k + j;
      if (s < 0 || idx >= txq.size()) n++;
      else if (txq[idx] !== e) n++;
    end
    return n;
  endfunction

  // Issue go with word d on DUT `which`, record outputs each negedge; index 0 is
  // the sample after the accepting edge. Stops `extra` samples after first done.
  task automatic capture(input int which, input logic [7:0] d, input bit hold,
                         input int extra, input int budget);
    logic t, bz, ff, dn;
    txq.delete(); busyq.delete(); fq.delete();
    done_idx = -1;
    done_cnt = 0;
    @(negedge ck);
    if (which == 1) begin b1.dato = d; b1.go = 1'b1; end
    else            begin b2.dato = d; b2.go = 1'b1; end
    for (int i = 0; i < budget; i++) begin
      @(negedge ck);
      if (which == 1) begin t = tx1; bz = b1.busy; ff = f1; dn = b1.done; end
      else            begin t = tx2; bz = b2.busy; ff = f2; dn = b2.done; end
      if (i == 0 && !hold) begin b1.go = 1'b0; b2.go = 1'b0; end
      txq.push_back(t); busyq.push_back(bz); fq.push_back(ff);
      if (dn === 1'b1) begin
        done_cnt++;
        if (done_idx < 0) done_idx = i;
      end
      if (done_idx >= 0 && i >= done_idx + extra) break;
    end
    b1.go = 1'b0;
    b2.go = 1'b0;
    if (done_idx < 0) begin
      n_checks++; n_fail++;
      $display("FAIL capture_timeout: no done within %0d cycles", budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge ck);
    n_checks++; if (tx1 !== 1'b1)     begin n_fail++; $display("FAIL reset_tx1: got %b want 1", tx1); end
    n_checks++; if (f1 !== 1'b0)      begin n_fail++; $display("FAIL reset_f1: got %b want 0", f1); end
    n_checks++; if (b1.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy1: got %b want 0", b1.busy); end
    n_checks++; if (b1.done !== 1'b0) begin n_fail++; $display("FAIL reset_done1: got %b want 0", b1.done); end
    n_checks++; if (tx2 !== 1'b1)     begin n_fail++; $display("FAIL reset_tx2: got %b want 1", tx2); end
    n_checks++; if (b2.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy2: got %b want 0", b2.busy); end
    rst = 1'b0;
    repeat (3) @(negedge ck);
    n_checks++; if (tx1 !== 1'b1 || f1 !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: tx=%b f=%b want tx=1 f=0", tx1, f1); end
  endtask

  task automatic test_frame(input int which, input logic [7:0] d, input int stops);
    int s, nl, e;
    nl = nlev(stops);
    capture(which, d, 1'b0, 20, 2000);
    s = first_zero(0);
    n_checks++; if (s !== 6) begin n_fail++; $display("FAIL start_latency d=%h: got %0d want 6", d, s); end
    for (int k = 0; k < nl; k++) begin
      e = level_err(s, k, exp_level(d, k));
      n_checks++;
      if (e !== 0) begin n_fail++; $display("FAIL level d=%h k=%0d: %0d bad samples, want 0", d, k, e); end
    end
    n_checks++; if (done_idx - s !== 10 * nl) begin n_fail++; $display("FAIL frame_len d=%h: got %0d want %0d", d, done_idx - s, 10 * nl); end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL done_count d=%h: got %0d want 1", d, done_cnt); end
    n_checks++; if (busyq[done_idx] !== 1'b0 || busyq[done_idx-1] !== 1'b1) begin
      n_fail++; $display("FAIL busy_fall d=%h: got %b%b want 10", d, busyq[done_idx-1], busyq[done_idx]); end
    n_checks++; if (fq[done_idx] !== 1'b0 || busyq[0] !== 1'b1 || fq[0] !== 1'b1) begin
      n_fail++; $display("FAIL f_busy_window d=%h: f0=%b busy0=%b f_end=%b want 1 1 0", d, fq[0], busyq[0], fq[done_idx]); end
  endtask

  task automatic test_basic();
    test_frame(1, 8'h55, 1);
    test_frame(1, 8'hC3, 1);
  endtask

  task automatic test_stop2();
    int s, run;
    test_frame(2, 8'h00, 2);
    s = first_zero(0);
    run = 0;
    while (s >= 0 && s + run < txq.size() && txq[s + run] === 1'b0) run++;
    n_checks++; if (run !== 90 + 10 * NPAR) begin n_fail++; $display("FAIL stop2_low_run: got %0d want %0d", run, 90 + 10 * NPAR); end
    n_checks++; if (done_idx - (s + run) !== 20) begin n_fail++; $display("FAIL stop2_high_run: got %0d want 20", done_idx - (s + run)); end
  endtask

  task automatic test_go_while_busy();
    int s, e, zeros;
    fork
      capture(1, 8'h3C, 1'b0, 150, 2000);
      begin
        repeat (45) @(negedge ck);
        b1.dato = 8'hFF; b1.go = 1'b1;
        @(negedge ck);
        b1.go = 1'b0;
      end
    join
    s = first_zero(0);
    for (int k = 0; k < nlev(1); k++) begin
      e = level_err(s, k, exp_level(8'h3C, k));
      n_checks++;
      if (e !== 0) begin n_fail++; $display("FAIL busy_go_level k=%0d: %0d bad samples, want 0", k, e); end
    end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL busy_go_done_count: got %0d want 1", done_cnt); end
    zeros = 0;
    for (int i = done_idx; i < txq.size(); i++) if (txq[i] !== 1'b1 || busyq[i] !== 1'b0) zeros++;
    n_checks++; if (zeros !== 0) begin n_fail++; $display("FAIL busy_go_second_frame: %0d active samples after done, want 0", zeros); end
  endtask

  task automatic test_reset_mid();
    @(negedge ck);
    b1.dato = 8'h00; b1.go = 1'b1;
    @(negedge ck);
    b1.go = 1'b0;
    repeat (50) @(negedge ck);
    n_checks++; if (tx1 !== 1'b0) begin n_fail++; $display("FAIL mid_frame_bit3: got %b want 0", tx1); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (tx1 !== 1'b1 || f1 !== 1'b0 || b1.busy !== 1'b0 || b1.done !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: tx=%b f=%b busy=%b done=%b want 1 0 0 0", tx1, f1, b1.busy, b1.done); end
    @(negedge ck);
    rst = 1'b0;
    test_frame(1, 8'hA5, 1);
  endtask

`ifdef UART_TX_PARIDAD_EN
  task automatic test_parity();
    int s;
    test_frame(1, 8'h55, 1);
    s = first_zero(0);
    n_checks++; if (level_err(s, 9, 1'b0) !== 0) begin n_fail++; $display("FAIL parity_55: bit 9 not 0"); end
    n_checks++; if (done_idx - s !== 110) begin n_fail++; $display("FAIL parity_len: got %0d want 110", done_idx - s); end
    test_frame(1, 8'h07, 1);
    s = first_zero(0);
    n_checks++; if (level_err(s, 9, 1'b1) !== 0) begin n_fail++; $display("FAIL parity_07: bit 9 not 1"); end
  endtask
`endif

  task automatic test_back_to_back();
    int s, d, s2, e, ones;
    capture(1, 8'h81, 1'b1, 105, 2000);
    s = first_zero(0);
    d = done_idx;
    ones = 0;
    for (int j = 0; j <= 6; j++) if (txq[d + j] !== 1'b1) ones++;
    n_checks++; if (ones !== 0) begin n_fail++; $display("FAIL b2b_gap: %0d low samples in realign gap, want 0", ones); end
    s2 = first_zero(d);
    n_checks++; if (s2 - d !== 7) begin n_fail++; $display("FAIL b2b_restart: next start %0d after done, want 7", s2 - d); end
    for (int k = 0; k < nlev(1) - 1; k++) begin
      e = level_err(s2, k, exp_level(8'h81, k));
      n_checks++;
      if (e !== 0) begin n_fail++; $display("FAIL b2b_level k=%0d: %0d bad samples, want 0", k, e); end
    end
    n_checks++; if (done_idx - s !== 100) begin n_fail++; $display("FAIL b2b_first_len: got %0d want 100", done_idx - s); end
    e = 0;
    for (int i = 0; i < 50 && !e; i++) begin
      @(negedge ck);
      if (b1.done === 1'b1) e = 1;
    end
    n_checks++; if (e !== 1) begin n_fail++; $display("FAIL b2b_second_done: got %0d want 1", e); end
    repeat (30) @(negedge ck);
    n_checks++; if (b1.busy !== 1'b0 || tx1 !== 1'b1) begin n_fail++; $display("FAIL b2b_idle: busy=%b tx=%b want 0 1", b1.busy, tx1); end
  endtask

  initial begin
    b1.go = 1'b0; b1.dato = '0;
    b2.go = 1'b0; b2.dato = '0;
    test_reset();
    test_basic();
    test_stop2();
    test_go_while_busy();
    test_reset_mid();
`ifdef UART_TX_PARIDAD_EN
    test_parity();
`endif
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
